simd_mult_lane_packer: RTL and testbench
========================================

Name: simd_mult_lane_packer

Overview:
- Collects independent signed 9x9 multiply requests from a valid/ready stream and packs up to 6 of them into one 54-bit A/B operand pair.
- Issues each pair to the packed six-lane multiplier (lane i: A[9i+8:9i] x B[9i+8:9i] -> 18-bit C_i).
- Captures the concatenated lane results and returns them as a tagged stream, one lane per cycle, in request order.
- Sits between scalar multiply producers and the SIMD-mapped DSP multiplier.

Parameters:
- LANES, 6, lanes per batch (1..6)
- LANE_W, 9, operand width per lane
- MULT_LAT, 3, multiplier pipeline latency in cycles (0 = combinational)
- FLUSH_TIMEOUT, 8, idle cycles in FILL before a partial batch is issued (0 = never)
- TAG_W, 4, request tag width

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_a  in  LANE_W  signed operand A
- in_b  in  LANE_W  signed operand B
- in_tag  in  TAG_W  request tag
- in_last  in  1  force issue after this request
- mult_a  out  LANES*LANE_W  packed A to multiplier
- mult_b  out  LANES*LANE_W  packed B to multiplier
- mult_issue  out  1  one-cycle strobe, operands valid
- mult_c  in  LANES*2*LANE_W  packed results {C_5..C_0}
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_p  out  2*LANE_W  signed product
- out_tag  out  TAG_W  tag of the originating request
- out_last  out  1  final lane of the batch

Behaviour:
- Reset (synchronous, active-high): FSM=FILL, count=0, timer=0. in_ready=1 and all other outputs 0. Lane registers are cleared to 0. Reset mid-batch discards all captured and in-flight data; a mult_c value arriving later is ignored.
- FILL state:
  - in_ready=1. Each accepted request writes lane[count] (a, b, tag), then count++.
  - Go to ISSUE when either: count reaches LANES, or the accepted request has in_last=1.
  - timer increments on each cycle with count>0 and no accept, and clears on accept. When timer==FLUSH_TIMEOUT-1 with count>0, go to ISSUE.
  - With count==0 the timer stays at 0. An empty batch is never issued.
- ISSUE state (1 cycle):
  - in_ready=0, mult_issue=1.
  - mult_a/mult_b carry lane i at bits [9i+8:9i]. Lanes >= count are driven with 0 operands.
  - Record n=count.
  - Next state: WAIT, or capture immediately when MULT_LAT=0.
- WAIT state:
  - A down-counter is loaded with MULT_LAT.
  - mult_c is registered into the result buffer exactly MULT_LAT cycles after the mult_issue cycle. Then go to DRAIN with idx=0.
- DRAIN state:
  - out_valid=1; out_p = result[18*idx+17 : 18*idx], out_tag = tag[idx], out_last = (idx==n-1).
  - Output holds stable while out_valid & !out_ready.
  - On handshake, idx++. After the handshake with idx==n-1, go to FILL with count=0.
  - in_ready=0 throughout ISSUE, WAIT and DRAIN. One batch is in flight at most.
- Arithmetic: products are signed 18-bit. Full range holds, e.g. (-256)*(-256)=65536.
- Ordering: results leave in acceptance order, lane 0 first.

Optional Feature:
- SIMD_PACK_STATS_EN
  - Defined: adds outputs stat_batches[15:0] (counts ISSUE cycles) and stat_partial[15:0] (counts ISSUE cycles with n<LANES). Both counters are cleared by RST and saturate at 16'hFFFF.
  - Undefined: neither port nor any counter logic exists.

Decomposition:
- Package simd_mult_pkg holds:
  - FSM state enum (FILL, ISSUE, WAIT, DRAIN)
  - LANE_W/LANES default constants
  - lane record typedef {a, b, tag}
  - function for the lane slice offset
- Sub-module simd_lane_unpack: result buffer plus drain index and valid/ready output logic. Instantiated once.

Test Plan:
- Six back-to-back requests (a=i+1, b=-(i+1), tag=i), MULT_LAT=3, out_ready=1:
  - one mult_issue.
  - out_p = -1,-4,-9,-16,-25,-36 on consecutive cycles, tags 0..5, out_last on the 6th.
- Two requests then idle, FLUSH_TIMEOUT=8:
  - issue 8 cycles after the second accept.
  - lanes 2..5 of mult_a/mult_b are 0.
  - exactly 2 results are returned.
- Single request (-256,-256) with in_last=1:
  - immediate ISSUE.
  - out_p=18'h10000 (65536), out_last=1.
- out_ready toggled 0/1 each cycle during DRAIN: every result is held stable while stalled, none is lost or duplicated, and in_ready stays 0 until the last handshake.
- RST asserted during WAIT:
  - next cycle state is FILL, in_ready=1, out_valid=0.
  - the returning mult_c is ignored.
  - a new batch completes correctly.
- With SIMD_PACK_STATS_EN, run 3 full batches and 2 timeout batches: stat_batches=5, stat_partial=2.

Source files
------------

// File: rtl/simd_mult_pkg.sv
// Shared types and constants for the packed six-lane signed multiplier front end.
package simd_mult_pkg;

  localparam int DEF_LANES  = 6;
  localparam int DEF_LANE_W = 9;
  localparam int DEF_TAG_W  = 4;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // One collected request; field widths follow the package defaults.
  typedef struct packed {
    logic signed [DEF_LANE_W-1:0] a;
    logic signed [DEF_LANE_W-1:0] b;
    logic [DEF_TAG_W-1:0]         tag;
  } lane_t;

  function automatic int lane_off(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/simd_lane_unpack.sv
// Result buffer for one packed multiply: holds the lane products and streams
// them out one lane per cycle with valid/ready, lane 0 first.
module simd_lane_unpack
  import simd_mult_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int CW     = $clog2(DEF_LANES + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        capture,
  input  logic [LANES*2*LANE_W-1:0]   mult_c,
  input  logic [CW-1:0]               n,
  input  logic [LANES*TAG_W-1:0]      tags,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [2*LANE_W-1:0]  out_p,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_last,
  output logic                        done
);

  localparam int PW = 2 * LANE_W;

  logic [LANES*PW-1:0] result_q;
  logic [CW-1:0]       idx_q;
  logic                active_q;
  logic                last_lane;

  assign last_lane = (idx_q == n - CW'(1));
  assign done      = active_q & out_ready & last_lane;
  assign out_valid = active_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (capture) begin
      result_q <= mult_c;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && out_ready) begin
      if (last_lane) active_q <= 1'b0;
      else           idx_q    <= idx_q + CW'(1);
    end
  end

  // Outputs stay at zero whenever nothing is being drained.
  always_comb begin
    out_p    = '0;
    out_tag  = '0;
    out_last = 1'b0;
    if (active_q) begin
      out_last = last_lane;
      for (int i = 0; i < LANES; i++) begin
        if (idx_q == CW'(i)) begin
          out_p   = result_q[lane_off(i, PW) +: PW];
          out_tag = tags[lane_off(i, TAG_W) +: TAG_W];
        end
      end
    end
  end

endmodule

// File: rtl/simd_mult_lane_packer.sv
// Packs scalar signed multiply requests into one SIMD multiplier issue and
// returns lane results in order. Optional counters: define SIMD_PACK_STATS_EN.
module simd_mult_lane_packer
  import simd_mult_pkg::*;
#(
  parameter int LANES         = DEF_LANES,
  parameter int LANE_W        = DEF_LANE_W,
  parameter int MULT_LAT      = 3,
  parameter int FLUSH_TIMEOUT = 8,
  parameter int TAG_W         = DEF_TAG_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [LANE_W-1:0]    in_a,
  input  logic signed [LANE_W-1:0]    in_b,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        in_last,
  output logic [LANES*LANE_W-1:0]     mult_a,
  output logic [LANES*LANE_W-1:0]     mult_b,
  output logic                        mult_issue,
  input  logic [LANES*2*LANE_W-1:0]   mult_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [2*LANE_W-1:0]  out_p,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_last
`ifdef SIMD_PACK_STATS_EN
  ,
  output logic [15:0]                 stat_batches,
  output logic [15:0]                 stat_partial
`endif
);

  localparam int CW = $clog2(LANES + 1);
  localparam int TW = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
  localparam int LW = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT + 1);

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      n_q;
  logic [TW-1:0]      timer_q;
  logic [LW-1:0]      lat_q;
  lane_t              lanes_q [LANES];
  logic               accept;
  logic               flush_hit;
  logic               capture;
  logic               drain_done;
  logic [LANES*TAG_W-1:0] tag_vec;

  assign in_ready   = (state_q == ST_FILL);
  assign accept     = in_valid & in_ready;
  assign mult_issue = (state_q == ST_ISSUE);

  // A timeout of zero disables the idle flush entirely.
  assign flush_hit = (FLUSH_TIMEOUT != 0) && (count_q != '0) && !accept &&
                     (timer_q == TW'(FLUSH_TIMEOUT - 1));

  assign capture = ((state_q == ST_ISSUE) && (MULT_LAT == 0)) ||
                   ((state_q == ST_WAIT) && (lat_q == LW'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FILL;
      count_q <= '0;
      n_q     <= '0;
      timer_q <= '0;
      lat_q   <= '0;
      // NOTE: the lane array is small and flop-based, so clearing it on reset
      // is cheap; large RAM-style arrays would normally be left unreset.
      for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            for (int i = 0; i < LANES; i++) begin
              if (count_q == CW'(i)) lanes_q[i] <= '{a: in_a, b: in_b, tag: in_tag};
            end
            count_q <= count_q + CW'(1);
            timer_q <= '0;
            if (count_q == CW'(LANES - 1) || in_last) state_q <= ST_ISSUE;
          end else if (count_q != '0) begin
            if (flush_hit) state_q <= ST_ISSUE;
            else           timer_q <= timer_q + TW'(1);
          end
        end
        ST_ISSUE: begin
          n_q     <= count_q;
          timer_q <= '0;
          lat_q   <= LW'(MULT_LAT);
          state_q <= (MULT_LAT == 0) ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          lat_q <= lat_q - LW'(1);
          if (capture) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_FILL;
            count_q <= '0;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // Unfilled lanes are forced to zero so stale operands never reach the DSP.
  // NOTE: every output of this block gets a default first, so no path through
  // the loop can leave a bit unassigned and infer a latch.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    if (state_q == ST_ISSUE) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < count_q) begin
          mult_a[lane_off(i, LANE_W) +: LANE_W] = lanes_q[i].a;
          mult_b[lane_off(i, LANE_W) +: LANE_W] = lanes_q[i].b;
        end
      end
    end
  end

  always_comb begin
    tag_vec = '0;
    for (int i = 0; i < LANES; i++) tag_vec[lane_off(i, TAG_W) +: TAG_W] = lanes_q[i].tag;
  end

  simd_lane_unpack #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .TAG_W  (TAG_W),
    .CW     (CW)
  ) u_unpack (
    .CLK       (CLK),
    .RST       (RST),
    .capture   (capture),
    .mult_c    (mult_c),
    .n         (n_q),
    .tags      (tag_vec),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .done      (drain_done)
  );

`ifdef SIMD_PACK_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_batches <= '0;
      stat_partial <= '0;
    end else if (state_q == ST_ISSUE) begin
      if (stat_batches != 16'hFFFF) stat_batches <= stat_batches + 16'd1;
      if (count_q != CW'(LANES) && stat_partial != 16'hFFFF)
        stat_partial <= stat_partial + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_mult_lane_packer.sv
// Bench for simd_mult_lane_packer: transaction-level model of batching and
// lane results, a behavioural pipelined multiplier, directed and random traffic.
module tb_simd_mult_lane_packer;

  localparam int LANES = 6;
  localparam int ML    = 3;
  localparam int FT    = 8;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [8:0]   in_a = '0;
  logic signed [8:0]   in_b = '0;
  logic [3:0]          in_tag = '0;
  logic                in_last = 1'b0;
  logic [53:0]         mult_a, mult_b;
  logic                mult_issue;
  logic [107:0]        mult_c;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [17:0]  out_p;
  logic [3:0]          out_tag;
  logic                out_last;
`ifdef SIMD_PACK_STATS_EN
  logic [15:0]         stat_batches, stat_partial;
`endif

  always #5 CLK = ~CLK;

  simd_mult_lane_packer #(
    .LANES(LANES), .LANE_W(9), .MULT_LAT(ML), .FLUSH_TIMEOUT(FT), .TAG_W(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .in_last(in_last),
    .mult_a(mult_a), .mult_b(mult_b), .mult_issue(mult_issue), .mult_c(mult_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_tag(out_tag), .out_last(out_last)
`ifdef SIMD_PACK_STATS_EN
    , .stat_batches(stat_batches), .stat_partial(stat_partial)
`endif
  );

  // Behavioural multiplier: six signed 9x9 lanes, ML register stages.
  function automatic logic [107:0] lane_products(input logic [53:0] a, input logic [53:0] b);
    logic [107:0] c;
    int x, y, p;
    c = '0;
    for (int i = 0; i < 6; i++) begin
      x = $signed(a[9*i +: 9]);
      y = $signed(b[9*i +: 9]);
      p = x * y;
      c[18*i +: 18] = p[17:0];
    end
    return c;
  endfunction

  logic [107:0] pipe [ML];
  always @(posedge CLK) begin
    pipe[0] <= lane_products(mult_a, mult_b);
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign mult_c = pipe[ML-1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: requests collect until full, last-flagged, or FT idle
  // cycles; a closed batch issues next cycle, results appear ML+1 cycles later.
  typedef struct { int a; int b; int tag; } req_t;
  typedef struct { logic [17:0] p; logic [3:0] tag; bit last; } res_t;

  req_t m_pend[$];
  req_t m_batch[$];
  res_t m_res[$];
  bit   m_busy = 1'b0;
  int   m_idle = 0;
  int   m_issue_at = -1;
  int   m_val_at = 0;
  int   m_batches = 0;
  int   m_partial = 0;
  int   cyc = 0;
  bit   chk_on = 1'b0;

  int          iss_cyc[$];
  logic [53:0] iss_a[$];
  logic [53:0] iss_b[$];
  logic [17:0] obs_p[$];
  logic [3:0]  obs_tag[$];
  bit          obs_last[$];
  int          obs_cyc[$];
  int          acc_cyc[$];

  task automatic close_batch();
    res_t r;
    int   p;
    m_busy     = 1'b1;
    m_issue_at = cyc + 1;
    m_val_at   = cyc + 2 + ML;
    m_batch    = m_pend;
    m_batches++;
    if (m_pend.size() < LANES) m_partial++;
    foreach (m_pend[i]) begin
      p      = m_pend[i].a * m_pend[i].b;
      r.p    = p[17:0];
      r.tag  = 4'(m_pend[i].tag);
      r.last = (i == m_pend.size() - 1);
      m_res.push_back(r);
    end
    m_pend.delete();
    m_idle = 0;
  endtask

  always @(negedge CLK) begin
    bit          exp_valid;
    logic [53:0] ea, eb;
    req_t        q;
    exp_valid = m_busy && (m_res.size() > 0) && (cyc >= m_val_at);
    if (chk_on) begin
      check("in_ready", in_ready, !m_busy);
      check("mult_issue", mult_issue, cyc == m_issue_at);
      if (cyc == m_issue_at) begin
        ea = '0;
        eb = '0;
        foreach (m_batch[i]) begin
          ea[9*i +: 9] = 9'(m_batch[i].a);
          eb[9*i +: 9] = 9'(m_batch[i].b);
        end
        check("mult_a", mult_a, ea);
        check("mult_b", mult_b, eb);
      end
      check("out_valid", out_valid, exp_valid);
      if (exp_valid && out_valid) begin
        check("out_p", $unsigned(out_p), m_res[0].p);
        check("out_tag", out_tag, m_res[0].tag);
        check("out_last", out_last, m_res[0].last);
      end
    end
    if (mult_issue === 1'b1) begin
      iss_cyc.push_back(cyc); iss_a.push_back(mult_a); iss_b.push_back(mult_b);
    end
    if (out_valid === 1'b1 && out_ready) begin
      obs_p.push_back($unsigned(out_p)); obs_tag.push_back(out_tag);
      obs_last.push_back(out_last); obs_cyc.push_back(cyc);
    end
    if (in_valid && in_ready === 1'b1) acc_cyc.push_back(cyc);

    if (RST) begin
      m_pend.delete(); m_batch.delete(); m_res.delete();
      m_busy = 1'b0; m_idle = 0; m_issue_at = -1; m_batches = 0; m_partial = 0;
    end else if (!m_busy && in_valid) begin
      q.a = in_a; q.b = in_b; q.tag = in_tag;
      m_pend.push_back(q);
      m_idle = 0;
      if (m_pend.size() == LANES || in_last) close_batch();
    end else if (!m_busy && m_pend.size() > 0) begin
      m_idle++;
      if (FT != 0 && m_idle == FT) close_batch();
    end else if (exp_valid && out_ready) begin
      if (m_res[0].last) m_busy = 1'b0;
      void'(m_res.pop_front());
    end
    cyc++;
  end

  int ordy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  always @(posedge CLK) begin
    #1;
    case (ordy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  task automatic clear_logs();
    iss_cyc.delete(); iss_a.delete(); iss_b.delete();
    obs_p.delete(); obs_tag.delete(); obs_last.delete(); obs_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input int a, input int b, input int tag, input bit last);
    logic acc;
    int   g;
    in_valid = 1'b1; in_a = 9'(a); in_b = 9'(b); in_tag = 4'(tag); in_last = last;
    g = 0;
    do begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      g++;
    end while (!acc && g < 300);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((m_busy || m_pend.size() != 0) && g < 400) begin
      @(posedge CLK);
      #1;
      g++;
    end
    check("idle_reached", g < 400, 1);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin @(posedge CLK); #1; end
  endtask

  initial begin
    logic [53:0] hi;
    logic [17:0] e;
    int          r, a, b;

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_on = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mult_issue", mult_issue, 0);
    check("rst_mult_a", mult_a, 0);
    check("rst_out_p", $unsigned(out_p), 0);

    // Six back-to-back requests: one full batch.
    clear_logs();
    for (int i = 0; i < 6; i++) send(i + 1, -(i + 1), i, 1'b0);
    wait_idle();
    check("full_issue_count", iss_cyc.size(), 1);
    check("full_result_count", obs_p.size(), 6);
    if (obs_p.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        e = 18'(-((i + 1) * (i + 1)));
        check("full_p", obs_p[i], e);
        check("full_tag", obs_tag[i], i);
        check("full_last", obs_last[i], i == 5);
        check("full_consecutive", obs_cyc[i] - obs_cyc[0], i);
      end
      check("full_p0_literal", obs_p[0], 18'h3FFFF);
      check("full_p5_literal", obs_p[5], 18'h3FFDC);
    end

    // Two requests then idle: flush after the timeout.
    clear_logs();
    send(37, -5, 9, 1'b0);
    send(-100, 200, 10, 1'b0);
    wait_idle();
    check("flush_issue_count", iss_cyc.size(), 1);
    if (iss_cyc.size() == 1 && acc_cyc.size() == 2) begin
      check("flush_delay", iss_cyc[0] - (acc_cyc[1] + 1), 8);
      hi = iss_a[0]; check("flush_a_upper_zero", hi[53:18], 0);
      hi = iss_b[0]; check("flush_b_upper_zero", hi[53:18], 0);
    end
    check("flush_result_count", obs_p.size(), 2);

    // Single extreme request with in_last.
    clear_logs();
    send(-256, -256, 7, 1'b1);
    wait_idle();
    check("last_issue_count", iss_cyc.size(), 1);
    if (iss_cyc.size() == 1 && acc_cyc.size() == 1)
      check("last_immediate", iss_cyc[0] - (acc_cyc[0] + 1), 0);
    check("last_result_count", obs_p.size(), 1);
    if (obs_p.size() == 1) begin
      check("last_p_65536", obs_p[0], 18'h10000);
      check("last_flag", obs_last[0], 1);
    end

    // Back-pressure: out_ready toggling during drain.
    clear_logs();
    ordy_mode = 1;
    for (int i = 0; i < 6; i++) send(-(i * 40), 3 * i - 7, 15 - i, 1'b0);
    wait_idle();
    ordy_mode = 0;
    check("stall_result_count", obs_p.size(), 6);
    if (obs_p.size() == 6)
      for (int i = 0; i < 6; i++) check("stall_tag_order", obs_tag[i], 15 - i);

    // Reset while waiting on the multiplier.
    clear_logs();
    send(11, 12, 1, 1'b0);
    send(-13, 14, 2, 1'b0);
    send(15, -16, 3, 1'b1);
    idle_cycles(1);
    RST = 1'b1;
    idle_cycles(1);
    RST = 1'b0;
    check("rst_wait_in_ready", in_ready, 1);
    check("rst_wait_out_valid", out_valid, 0);
    idle_cycles(8);
    check("rst_wait_no_results", obs_p.size(), 0);
    send(100, -3, 4, 1'b0);
    send(-7, -7, 5, 1'b1);
    wait_idle();
    check("rst_wait_new_results", obs_p.size(), 2);
    if (obs_p.size() == 2) check("rst_wait_new_p1", obs_p[1], 18'd49);

    // Randomized traffic with random back-pressure and gaps.
    ordy_mode = 2;
    for (int i = 0; i < 90; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) idle_cycles($urandom_range(4, 12));
      r = $urandom_range(0, 7);
      a = (r == 0) ? -256 : (r == 1) ? 255 : $signed(9'($urandom));
      r = $urandom_range(0, 7);
      b = (r == 0) ? -256 : (r == 1) ? 255 : $signed(9'($urandom));
      send(a, b, $urandom_range(0, 15), $urandom_range(0, 5) == 0);
    end
    wait_idle();
    ordy_mode = 0;

`ifdef SIMD_PACK_STATS_EN
    RST = 1'b1;
    idle_cycles(1);
    RST = 1'b0;
    check("stat_rst_batches", stat_batches, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) send(i, k, i, 1'b0);
      wait_idle();
    end
    for (int k = 0; k < 2; k++) begin
      send(k, 2, 0, 1'b0);
      send(3, k, 1, 1'b0);
      wait_idle();
    end
    check("stat_batches", stat_batches, 5);
    check("stat_partial", stat_partial, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
